// File: rtl/ram_pkg.sv
// Shared types and helpers for the single-write, multi-read RAM with clear sequencer.
package ram_pkg;

  localparam int unsigned RAM_MAX_W   = 256;
  localparam int unsigned RAM_IDX_W   = 8;

  typedef enum logic [1:0] {
    RUW_READ_FIRST  = 2'd0,
    RUW_WRITE_FIRST = 2'd1,
    RUW_DONT_CARE   = 2'd2
  } ruw_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } ram_state_e;

  // Lane-wise merge: lanes with mask set take new_word, others keep old_word.
  function automatic logic [RAM_MAX_W-1:0] lane_merge(
    input logic [RAM_MAX_W-1:0] old_word,
    input logic [RAM_MAX_W-1:0] new_word,
    input logic [RAM_MAX_W-1:0] mask,
    input int unsigned          lane_w
  );
    logic [RAM_MAX_W-1:0] res;
    res = old_word;
    for (int unsigned b = 0; b < RAM_MAX_W; b++) begin
      if (mask[RAM_IDX_W'(b / lane_w)]) res[RAM_IDX_W'(b)] = new_word[RAM_IDX_W'(b)];
    end
    return res;
  endfunction

endpackage

// File: rtl/ram_rd_port.sv
// One synchronous read port: capture, write-first bypass and optional output stage.
module ram_rd_port
  import ram_pkg::*;
#(
  parameter int unsigned WW      = 32,
  parameter int unsigned AW      = 5,
  parameter int unsigned MW      = 4,
  parameter ruw_e        RUW     = RUW_READ_FIRST,
  parameter bit          OUT_REG = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  input  logic [WW-1:0] old_word,
  input  logic          wr_fire,
  input  logic [AW-1:0] wr_addr,
  input  logic [WW-1:0] wr_data,
  input  logic [MW-1:0] wr_mask,
  output logic [WW-1:0] rd_data,
  output logic          rd_valid
);

  localparam int unsigned LW = WW / MW;

  logic          bypass_c;
  logic [WW-1:0] cap_word_c;
  logic [WW-1:0] s1_data;
  logic          s1_valid;

  // Same-edge write to the read address is forwarded only in write-first mode.
  always_comb begin
    bypass_c   = (RUW == RUW_WRITE_FIRST) && wr_fire && (rd_addr == wr_addr);
    cap_word_c = old_word;
    if (bypass_c) begin
      cap_word_c = WW'(lane_merge(RAM_MAX_W'(old_word), RAM_MAX_W'(wr_data),
                                  RAM_MAX_W'(wr_mask), LW));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= rd_en;
      if (rd_en) s1_data <= cap_word_c;
    end
  end

  if (OUT_REG) begin : g_out_reg
    logic [WW-1:0] s2_data;
    logic          s2_valid;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        s2_data  <= '0;
        s2_valid <= 1'b0;
      end else begin
        s2_valid <= s1_valid;
        if (s1_valid) s2_data <= s1_data;
      end
    end

    assign rd_data  = s2_data;
    assign rd_valid = s2_valid;
  end else begin : g_no_out_reg
    assign rd_data  = s1_data;
    assign rd_valid = s1_valid;
  end

endmodule

// File: rtl/ram_1w_nr_clr.sv
// Single-clock RAM: one masked write port, N synchronous read ports, hardware clear sequencer.
module ram_1w_nr_clr
  import ram_pkg::*;
#(
  parameter string       ramname        = "undefined",
  parameter int unsigned wordCount      = 32,
  parameter int unsigned wordWidth      = 32,
  parameter int unsigned addrWidth      = 5,
  parameter int unsigned maskWidth      = 4,
  parameter bit          maskEnable     = 1'b1,
  parameter int unsigned readPorts      = 2,
  parameter string       readUnderWrite = "readFirst",
  parameter bit          outputReg      = 1'b0,
  parameter bit          clearOnReset   = 1'b1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clr_req,
  output logic                           busy,
  input  logic                           wr_en,
  input  logic [maskWidth-1:0]           wr_mask,
  input  logic [addrWidth-1:0]           wr_addr,
  input  logic [wordWidth-1:0]           wr_data,
  input  logic [readPorts-1:0]           rd_en,
  input  logic [readPorts*addrWidth-1:0] rd_addr,
  output logic [readPorts*wordWidth-1:0] rd_data,
  output logic [readPorts-1:0]           rd_valid,
  input  logic                           CMBIST,
  input  logic                           CMATPG,
  input  logic [2:0]                     sramtrm
);

  localparam int unsigned LW  = wordWidth / maskWidth;
  localparam int unsigned IW  = (wordCount > 1) ? $clog2(wordCount) : 1;
  localparam int unsigned AW1 = addrWidth + 1;
  localparam ruw_e RUW = (readUnderWrite == "writeFirst") ? RUW_WRITE_FIRST :
                         (readUnderWrite == "dontCare")   ? RUW_DONT_CARE   : RUW_READ_FIRST;
  localparam ram_state_e RST_STATE = clearOnReset ? ST_CLEAR : ST_IDLE;
  localparam bit unused_tag = (ramname == "");

  // Configuration checks
  if (!(readUnderWrite == "readFirst" || readUnderWrite == "writeFirst" ||
        readUnderWrite == "dontCare")) begin : g_err_ruw
    $error("ram_1w_nr_clr: readUnderWrite must be readFirst, writeFirst or dontCare");
  end
  if (maskWidth == 0 || (wordWidth % maskWidth) != 0) begin : g_err_mask
    $error("ram_1w_nr_clr: wordWidth must be divisible by maskWidth");
  end
  if ((64'(1) << addrWidth) < 64'(wordCount)) begin : g_err_addr
    $error("ram_1w_nr_clr: addrWidth too small for wordCount");
  end
  if (readPorts < 1 || readPorts > 4) begin : g_err_ports
    $error("ram_1w_nr_clr: readPorts must be 1..4");
  end
  if (wordWidth > RAM_MAX_W) begin : g_err_width
    $error("ram_1w_nr_clr: wordWidth exceeds lane_merge limit");
  end

  logic unused_pins;
  assign unused_pins = ^{CMBIST, CMATPG, sramtrm};

  logic [wordWidth-1:0] mem [0:wordCount-1];

  ram_state_e           state, state_next;
  logic [IW-1:0]        cnt, cnt_next;
  logic                 wr_in_range_c;
  logic                 wr_fire_c;
  logic [maskWidth-1:0] wr_mask_eff_c;
  logic [wordWidth-1:0] wr_word_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RST_STATE;
      cnt   <= '0;
      busy  <= clearOnReset;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      busy  <= (state_next == ST_CLEAR);
    end
  end

  // Clear sequencer: one word per cycle, clr_req ignored once running.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ST_IDLE: begin
        cnt_next = '0;
        if (clr_req) state_next = ST_CLEAR;
      end
      ST_CLEAR: begin
        if (cnt == IW'(wordCount - 1)) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + IW'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_in_range_c = {1'b0, wr_addr} < AW1'(wordCount);
    wr_fire_c     = wr_en && !busy && wr_in_range_c;
    wr_mask_eff_c = maskEnable ? wr_mask : '1;
    wr_word_c     = wordWidth'(lane_merge(RAM_MAX_W'(mem[IW'(wr_addr)]), RAM_MAX_W'(wr_data),
                                          RAM_MAX_W'(wr_mask_eff_c), LW));
  end

  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) mem[cnt] <= '0;
    else if (wr_fire_c)    mem[IW'(wr_addr)] <= wr_word_c;
  end

  for (genvar p = 0; p < readPorts; p++) begin : g_rd
    logic [addrWidth-1:0] addr_c;
    logic                 in_range_c;
    logic [wordWidth-1:0] old_c;

    // Out-of-range reads return zero but still report valid.
    assign addr_c     = rd_addr[p*addrWidth +: addrWidth];
    assign in_range_c = {1'b0, addr_c} < AW1'(wordCount);
    assign old_c      = in_range_c ? mem[IW'(addr_c)] : '0;

    ram_rd_port #(
      .WW      (wordWidth),
      .AW      (addrWidth),
      .MW      (maskWidth),
      .RUW     (RUW),
      .OUT_REG (outputReg)
    ) u_rd_port (
      .clk      (clk),
      .reset    (reset),
      .rd_en    (rd_en[p] && !busy),
      .rd_addr  (addr_c),
      .old_word (old_c),
      .wr_fire  (wr_fire_c),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .wr_mask  (wr_mask_eff_c),
      .rd_data  (rd_data[p*wordWidth +: wordWidth]),
      .rd_valid (rd_valid[p])
    );
  end

endmodule

// File: tb/tb_ram_1w_nr_clr.sv
// Self-checking bench: three RAM configurations share stimulus and one behavioural model.
module tb_ram_1w_nr_clr;

  localparam int NW = 32;
  localparam int NP = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clr_req = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_mask = '0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [1:0]  rd_en = '0;
  logic [9:0]  rd_addr = '0;

  logic        busy_a, busy_w, busy_o;
  logic [63:0] rdd_a, rdd_w, rdd_o;
  logic [1:0]  rdv_a, rdv_w, rdv_o;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  logic [31:0] mdl [NW];
  int          clr_left = NW;
  bit          e_busy = 1'b1;
  logic [1:0]  e_v1 = '0, e_v2 = '0;
  logic [63:0] e_d1_rf = '0, e_d1_wf = '0, e_d2 = '0;

  always #5 clk = ~clk;

  ram_1w_nr_clr #(.readUnderWrite("readFirst"), .outputReg(1'b0)) dut_a (
    .clk(clk), .reset(reset), .clr_req(clr_req), .busy(busy_a), .wr_en(wr_en),
    .wr_mask(wr_mask), .wr_addr(wr_addr), .wr_data(wr_data), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rdd_a), .rd_valid(rdv_a),
    .CMBIST(1'b0), .CMATPG(1'b0), .sramtrm(3'b000));

  ram_1w_nr_clr #(.readUnderWrite("writeFirst"), .outputReg(1'b0)) dut_w (
    .clk(clk), .reset(reset), .clr_req(clr_req), .busy(busy_w), .wr_en(wr_en),
    .wr_mask(wr_mask), .wr_addr(wr_addr), .wr_data(wr_data), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rdd_w), .rd_valid(rdv_w),
    .CMBIST(1'b0), .CMATPG(1'b0), .sramtrm(3'b000));

  ram_1w_nr_clr #(.readUnderWrite("readFirst"), .outputReg(1'b1)) dut_o (
    .clk(clk), .reset(reset), .clr_req(clr_req), .busy(busy_o), .wr_en(wr_en),
    .wr_mask(wr_mask), .wr_addr(wr_addr), .wr_data(wr_data), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rdd_o), .rd_valid(rdv_o),
    .CMBIST(1'b0), .CMATPG(1'b0), .sramtrm(3'b000));

  task automatic drive_idle();
    clr_req = 1'b0; wr_en = 1'b0; wr_mask = '0; wr_addr = '0; wr_data = '0;
    rd_en = '0; rd_addr = '0;
  endtask

  task automatic model_reset();
    clr_left = NW; e_busy = 1'b1;
    e_v1 = '0; e_v2 = '0; e_d1_rf = '0; e_d1_wf = '0; e_d2 = '0;
  endtask

  // Apply the current inputs to the model, then advance one clock edge.
  task automatic tick();
    logic [31:0] old_w, mrg;
    logic [4:0]  a;
    for (int p = 0; p < NP; p++) if (e_v1[p]) e_d2[p*32 +: 32] = e_d1_rf[p*32 +: 32];
    e_v2 = e_v1;
    if (clr_left > 0) begin
      mdl[NW - clr_left] = '0;
      clr_left--;
      e_v1 = '0;
    end else begin
      for (int p = 0; p < NP; p++) begin
        if (rd_en[p]) begin
          a = rd_addr[p*5 +: 5];
          old_w = mdl[a];
          mrg = old_w;
          if (wr_en && a == wr_addr)
            for (int l = 0; l < 4; l++) if (wr_mask[l]) mrg[l*8 +: 8] = wr_data[l*8 +: 8];
          e_d1_rf[p*32 +: 32] = old_w;
          e_d1_wf[p*32 +: 32] = mrg;
          e_v1[p] = 1'b1;
        end else begin
          e_v1[p] = 1'b0;
        end
      end
      if (wr_en)
        for (int l = 0; l < 4; l++) if (wr_mask[l]) mdl[wr_addr][l*8 +: 8] = wr_data[l*8 +: 8];
      if (clr_req) clr_left = NW;
    end
    e_busy = (clr_left > 0);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int busy_cycles;
    busy_cycles = 0;
    drive_idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy_a !== 1'b1 || rdv_a !== 2'b00 || rdd_a !== 64'd0 || rdv_o !== 2'b00 || rdd_o !== 64'd0)
      begin errors++; $display("FAIL reset_values: busy=%b v=%b d=%h vo=%b do=%h, required busy=1 v=0 d=0",
                               busy_a, rdv_a, rdd_a, rdv_o, rdd_o); end
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 40; i++) begin
      if (busy_a) busy_cycles++;
      tick();
      checks++;
      if ({busy_a, busy_w, busy_o} !== {3{e_busy}})
        begin errors++; $display("FAIL reset_busy cycle %0d: got %b required %b", i, {busy_a, busy_w, busy_o}, {3{e_busy}}); end
    end
    checks++;
    if (busy_cycles != 32)
      begin errors++; $display("FAIL reset_busy_len: got %0d required 32", busy_cycles); end
  endtask

  task automatic test_clear_reads();
    for (int a = 0; a < NW; a += 2) begin
      drive_idle();
      rd_en = 2'b11;
      rd_addr = {5'(a + 1), 5'(a)};
      tick();
      checks++;
      if (rdv_a !== 2'b11 || rdd_a !== 64'd0 || rdd_o !== e_d2)
        begin errors++; $display("FAIL clear_read addr %0d: v=%b d=%h required v=11 d=0", a, rdv_a, rdd_a); end
    end
    drive_idle();
    tick();
  endtask

  task automatic test_masked_write();
    drive_idle();
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hAABBCCDD; wr_mask = 4'hF;
    tick();
    wr_data = 32'h11223344; wr_mask = 4'h5;
    tick();
    drive_idle();
    rd_en = 2'b01; rd_addr = {5'd0, 5'd5};
    tick();
    checks++;
    if (rdv_a !== 2'b01 || rdd_a[31:0] !== 32'hAA22CC44)
      begin errors++; $display("FAIL masked_write: v=%b d=%h required v=01 d=aa22cc44", rdv_a, rdd_a[31:0]); end
    drive_idle();
    tick();
    checks++;
    if (rdv_a !== 2'b00 || rdd_a[31:0] !== 32'hAA22CC44)
      begin errors++; $display("FAIL read_hold: v=%b d=%h required v=00 d=aa22cc44", rdv_a, rdd_a[31:0]); end
  endtask

  task automatic test_collision();
    drive_idle();
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h12345678; wr_mask = 4'hF;
    tick();
    wr_data = 32'hFFFFFFFF; wr_mask = 4'h3;
    rd_en = 2'b10; rd_addr = {5'd7, 5'd0};
    tick();
    checks++;
    if (rdv_a !== 2'b10 || rdd_a[63:32] !== 32'h12345678)
      begin errors++; $display("FAIL ruw_read_first: v=%b d=%h required v=10 d=12345678", rdv_a, rdd_a[63:32]); end
    checks++;
    if (rdv_w !== 2'b10 || rdd_w[63:32] !== 32'h1234FFFF)
      begin errors++; $display("FAIL ruw_write_first: v=%b d=%h required v=10 d=1234ffff", rdv_w, rdd_w[63:32]); end
    drive_idle();
    rd_en = 2'b10; rd_addr = {5'd7, 5'd0};
    tick();
    checks++;
    if (rdv_o !== 2'b10 || rdd_o[63:32] !== 32'h12345678 || rdd_a[63:32] !== 32'h1234FFFF)
      begin errors++; $display("FAIL ruw_after: vo=%b do=%h da=%h required vo=10 do=12345678 da=1234ffff",
                               rdv_o, rdd_o[63:32], rdd_a[63:32]); end
    drive_idle();
    tick();
  endtask

  task automatic test_busy_block();
    int busy_cycles;
    busy_cycles = 0;
    drive_idle();
    clr_req = 1'b1;
    tick();
    checks++;
    if (busy_a !== 1'b1)
      begin errors++; $display("FAIL clr_start: busy=%b required 1", busy_a); end
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hDEADBEEF; wr_mask = 4'hF;
    rd_en = 2'b11; rd_addr = {5'd3, 5'd3};
    for (int i = 0; i < 40 && busy_a; i++) begin
      clr_req = (i == 5);
      busy_cycles++;
      tick();
      checks++;
      if (rdv_a !== 2'b00 || rdv_w !== 2'b00 || rdv_o !== 2'b00)
        begin errors++; $display("FAIL busy_valid cycle %0d: a=%b w=%b o=%b required 00", i, rdv_a, rdv_w, rdv_o); end
    end
    checks++;
    if (busy_cycles != 32)
      begin errors++; $display("FAIL clr_len: got %0d required 32", busy_cycles); end
    drive_idle();
    rd_en = 2'b11; rd_addr = {5'd3, 5'd3};
    tick();
    checks++;
    if (rdv_a !== 2'b11 || rdd_a !== 64'd0)
      begin errors++; $display("FAIL busy_write_dropped: v=%b d=%h required v=11 d=0", rdv_a, rdd_a); end
    drive_idle();
    tick();
  endtask

  task automatic test_reset_mid_clear();
    int busy_cycles;
    busy_cycles = 0;
    drive_idle();
    wr_en = 1'b1; wr_addr = 5'd20; wr_data = 32'h55AA55AA; wr_mask = 4'hF;
    tick();
    drive_idle();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    model_reset();
    @(posedge clk); #1;
    checks++;
    if (busy_a !== 1'b1 || rdv_a !== 2'b00)
      begin errors++; $display("FAIL midclr_reset: busy=%b v=%b required busy=1 v=00", busy_a, rdv_a); end
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (busy_a) busy_cycles++;
      tick();
    end
    checks++;
    if (busy_cycles != 32)
      begin errors++; $display("FAIL midclr_len: got %0d required 32", busy_cycles); end
    rd_en = 2'b01; rd_addr = {5'd0, 5'd20};
    tick();
    checks++;
    if (rdv_a !== 2'b01 || rdd_a[31:0] !== 32'd0)
      begin errors++; $display("FAIL midclr_restart: v=%b d=%h required v=01 d=0", rdv_a, rdd_a[31:0]); end
    drive_idle();
    tick();
  endtask

  task automatic test_multiport_latency();
    drive_idle();
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h0BADF00D; wr_mask = 4'hF;
    tick();
    drive_idle();
    rd_en = 2'b11; rd_addr = {5'd9, 5'd9};
    tick();
    checks++;
    if (rdv_o !== 2'b00 || rdv_a !== 2'b11 || rdd_a !== {2{32'h0BADF00D}})
      begin errors++; $display("FAIL lat_first: vo=%b va=%b da=%h required vo=00 va=11 da=0badf00d x2", rdv_o, rdv_a, rdd_a); end
    drive_idle();
    tick();
    checks++;
    if (rdv_o !== 2'b11 || rdd_o !== {2{32'h0BADF00D}})
      begin errors++; $display("FAIL lat_second: vo=%b do=%h required vo=11 do=0badf00d x2", rdv_o, rdd_o); end
    tick();
    checks++;
    if (rdv_o !== 2'b00 || rdd_o !== {2{32'h0BADF00D}})
      begin errors++; $display("FAIL lat_third: vo=%b do=%h required vo=00 held", rdv_o, rdd_o); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      wr_en   = 1'($urandom_range(0, 1));
      wr_addr = 5'($urandom_range(0, 31));
      wr_data = $urandom;
      wr_mask = 4'($urandom_range(0, 15));
      rd_en   = 2'($urandom_range(0, 3));
      for (int p = 0; p < NP; p++)
        rd_addr[p*5 +: 5] = ($urandom_range(0, 2) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      clr_req = ($urandom_range(0, 99) == 0);
      tick();
      checks++;
      if ({busy_a, busy_w, busy_o} !== {3{e_busy}})
        begin errors++; $display("FAIL rand_busy cycle %0d: got %b required %b", i, {busy_a, busy_w, busy_o}, {3{e_busy}}); end
      checks++;
      if (rdv_a !== e_v1 || rdd_a !== e_d1_rf)
        begin errors++; $display("FAIL rand_read_first cycle %0d: v=%b d=%h required v=%b d=%h", i, rdv_a, rdd_a, e_v1, e_d1_rf); end
      checks++;
      if (rdv_w !== e_v1 || rdd_w !== e_d1_wf)
        begin errors++; $display("FAIL rand_write_first cycle %0d: v=%b d=%h required v=%b d=%h", i, rdv_w, rdd_w, e_v1, e_d1_wf); end
      checks++;
      if (rdv_o !== e_v2 || rdd_o !== e_d2)
        begin errors++; $display("FAIL rand_out_reg cycle %0d: v=%b d=%h required v=%b d=%h", i, rdv_o, rdd_o, e_v2, e_d2); end
    end
    drive_idle();
  endtask

  initial begin
    for (int i = 0; i < NW; i++) mdl[i] = '0;
    test_reset();
    test_clear_reads();
    test_masked_write();
    test_collision();
    test_busy_block();
    test_reset_mid_clear();
    test_multiport_latency();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule
